// File: rtl/ghost_typist.sv
// ghost_typist: scripted typing-race opponent. Fetches dictionary words by id
// and types each letter as a make/break pair followed by a space, at a pace
// set by speed. Key events share the scorer's interface (key_down, last_change,
// key_valid).
// Optional build macro GHOST_TYPO_EN: an LFSR occasionally makes the ghost
// type a wrong letter, erase it with BACK, then type the correct letter.
module ghost_typist #(
  parameter int         HOLD_TICKS = 2,
  parameter logic [7:0] ID_STEP    = 8'd37,
  parameter int         MAX_LEN    = 15
) (
  input  logic                   clk_div,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             seed,
  input  logic [6:0]             speed,
  input  logic [6:0]             target,
  input  logic [5*MAX_LEN-1:0]   word_in,
  input  logic [4:0]             wordnum,
  output logic [7:0]             word_id,
  output logic [127:0]           key_down,
  output logic [8:0]             last_change,
  output logic                   key_valid,
  output logic [6:0]             ghost_num,
  output logic [4:0]             ghost_pos,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_PRESS, ST_HOLD, ST_RELEASE, ST_GAP, ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_LETTER, K_SPACE, K_TYPO, K_BACK
  } kind_t;

  localparam logic [8:0]  SCAN_SPACE = 9'd41;
  localparam logic [15:0] HOLD_LOAD  = (HOLD_TICKS > 1) ? 16'(HOLD_TICKS - 2) : 16'd0;

  state_t                 state, state_next;
  logic [5*MAX_LEN-1:0]   word_reg;
  logic [4:0]             len_reg;
  logic [15:0]            tick_cnt;
  logic [8:0]             key_reg;
  kind_t                  kind_reg;

  logic [4:0]             letter_code;
  logic                   is_letter;
  logic [8:0]             sel_code;
  kind_t                  sel_kind;
  logic [8:0]             active_code;
  logic [6:0]             gap_len;
  logic [6:0]             tgt;
  logic [15:0]            gap_load;
  logic                   finish_rel;
  logic                   finish_gap;

`ifdef GHOST_TYPO_EN
  typedef enum logic [1:0] {PH_NONE, PH_BACK, PH_FIX} phase_t;
  phase_t      phase;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [4:0]  wrong_code;
`endif

  function automatic logic [8:0] scan_of(input logic [4:0] code);
    case (code)
      5'd1:  scan_of = 9'd28;
      5'd2:  scan_of = 9'd50;
      5'd3:  scan_of = 9'd33;
      5'd4:  scan_of = 9'd35;
      5'd5:  scan_of = 9'd36;
      5'd6:  scan_of = 9'd43;
      5'd7:  scan_of = 9'd52;
      5'd8:  scan_of = 9'd51;
      5'd9:  scan_of = 9'd67;
      5'd10: scan_of = 9'd59;
      5'd11: scan_of = 9'd66;
      5'd12: scan_of = 9'd75;
      5'd13: scan_of = 9'd58;
      5'd14: scan_of = 9'd49;
      5'd15: scan_of = 9'd68;
      5'd16: scan_of = 9'd77;
      5'd17: scan_of = 9'd21;
      5'd18: scan_of = 9'd45;
      5'd19: scan_of = 9'd27;
      5'd20: scan_of = 9'd44;
      5'd21: scan_of = 9'd60;
      5'd22: scan_of = 9'd42;
      5'd23: scan_of = 9'd29;
      5'd24: scan_of = 9'd34;
      5'd25: scan_of = 9'd53;
      5'd26: scan_of = 9'd26;
      default: scan_of = SCAN_SPACE;
    endcase
  endfunction

  // Pick the key to press next: the current letter of the latched word, or SPACE
  // once the word is exhausted or the slot holds a non-letter code.
  always_comb begin
    letter_code = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (ghost_pos == 5'(i)) letter_code = word_reg[5*i +: 5];
    end
    is_letter = (ghost_pos < len_reg) && (letter_code >= 5'd1) && (letter_code <= 5'd26);
    sel_code  = SCAN_SPACE;
    sel_kind  = K_SPACE;
`ifdef GHOST_TYPO_EN
    wrong_code = (letter_code == 5'd26) ? 5'd1 : letter_code + 5'd1;
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (phase == PH_BACK) begin
      sel_code = 9'd102;
      sel_kind = K_BACK;
    end else if (is_letter && phase == PH_NONE && lfsr[2:0] == 3'd0) begin
      sel_code = scan_of(wrong_code);
      sel_kind = K_TYPO;
    end else if (is_letter) begin
      sel_code = scan_of(letter_code);
      sel_kind = K_LETTER;
    end
`else
    if (is_letter) begin
      sel_code = scan_of(letter_code);
      sel_kind = K_LETTER;
    end
`endif
  end

  // State register; reset drops straight to IDLE so every output clears at once.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and key outputs. The release cycle doubles as the first gap tick,
  // so the letter period is HOLD_TICKS + max(speed,1) and GAP itself is skipped
  // when that gap is a single tick.
  always_comb begin
    gap_len    = (speed == 7'd0) ? 7'd1 : speed;
    tgt        = (target == 7'd0) ? 7'd1 : target;
    gap_load   = {9'd0, gap_len} - 16'd2;
    finish_rel = (kind_reg == K_SPACE) && ((ghost_num + 7'd1) == tgt);
    finish_gap = (kind_reg == K_SPACE) && (ghost_num == tgt);
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_LATCH;
      ST_LATCH:   state_next = ST_PRESS;
      ST_PRESS:   state_next = (HOLD_TICKS > 1) ? ST_HOLD : ST_RELEASE;
      ST_HOLD:    if (tick_cnt == 16'd0) state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (gap_len != 7'd1)            state_next = ST_GAP;
        else if (kind_reg != K_SPACE)   state_next = ST_PRESS;
        else                            state_next = finish_rel ? ST_DONE : ST_FETCH;
      end
      ST_GAP: begin
        if (tick_cnt == 16'd0) begin
          if (kind_reg != K_SPACE) state_next = ST_PRESS;
          else                     state_next = finish_gap ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:    if (!start) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (!start && state != ST_IDLE && state != ST_DONE) state_next = ST_IDLE;

    active_code = (state == ST_PRESS) ? sel_code : key_reg;
    key_down    = '0;
    if (state == ST_PRESS || state == ST_HOLD) key_down = 128'(1) << active_code;
    key_valid   = (state == ST_PRESS) || (state == ST_RELEASE);
    last_change = active_code;
    busy        = (state != ST_IDLE) && (state != ST_DONE);
    done        = (state == ST_DONE);
  end

  // Word latch, tick counter, progress counters and the remembered key.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      word_id   <= '0;
      ghost_num <= '0;
      ghost_pos <= '0;
      word_reg  <= '0;
      len_reg   <= '0;
      tick_cnt  <= '0;
      key_reg   <= '0;
      kind_reg  <= K_LETTER;
`ifdef GHOST_TYPO_EN
      phase     <= PH_NONE;
      lfsr      <= 8'hA5;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_id   <= seed;
            ghost_num <= '0;
            ghost_pos <= '0;
`ifdef GHOST_TYPO_EN
            phase     <= PH_NONE;
`endif
          end
        end
        ST_LATCH: begin
          word_reg <= word_in;
          len_reg  <= (wordnum > 5'(MAX_LEN)) ? 5'(MAX_LEN) : wordnum;
        end
        ST_PRESS: begin
          key_reg  <= sel_code;
          kind_reg <= sel_kind;
          tick_cnt <= HOLD_LOAD;
`ifdef GHOST_TYPO_EN
          if (is_letter && phase == PH_NONE) lfsr <= lfsr_next;
`endif
        end
        ST_HOLD, ST_GAP: tick_cnt <= tick_cnt - 16'd1;
        ST_RELEASE: begin
          tick_cnt <= gap_load;
          case (kind_reg)
            K_LETTER: begin
              ghost_pos <= ghost_pos + 5'd1;
`ifdef GHOST_TYPO_EN
              phase     <= PH_NONE;
`endif
            end
            K_SPACE: begin
              ghost_num <= ghost_num + 7'd1;
              ghost_pos <= '0;
              word_id   <= word_id + ID_STEP;
            end
`ifdef GHOST_TYPO_EN
            K_TYPO:  phase <= PH_BACK;
            K_BACK:  phase <= PH_FIX;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_typist.sv
// tb_ghost_typist: directed, table-driven bench for ghost_typist with
// hand-computed event timelines and a few multi-cycle corner sequences.
module tb_ghost_typist;

  logic          clk_div = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    seed = '0;
  logic [6:0]    speed = '0;
  logic [6:0]    target = '0;
  logic [74:0]   word_in = '0;
  logic [4:0]    wordnum = '0;
  logic [7:0]    word_id;
  logic [127:0]  key_down;
  logic [8:0]    last_change;
  logic          key_valid;
  logic [6:0]    ghost_num;
  logic [4:0]    ghost_pos;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        kv;
    logic [8:0]  lc;
    logic [8:0]  kd;
    logic [6:0]  num;
    logic [4:0]  pos;
    logic [7:0]  wid;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[18];

  int          pulse_cyc[$];
  logic [8:0]  pulse_code[$];
  logic        pulse_make[$];
  logic [7:0]  make_wid[$];
  logic [4:0]  make_pos[$];

  int scan_tbl[27] = '{0, 28, 50, 33, 35, 36, 43, 52, 51, 67, 59, 66, 75, 58,
                       49, 68, 77, 21, 45, 27, 44, 60, 42, 29, 34, 53, 26};

  ghost_typist #(.HOLD_TICKS(2), .ID_STEP(8'd37), .MAX_LEN(15)) dut (
    .clk_div(clk_div), .rst(rst), .start(start), .seed(seed), .speed(speed),
    .target(target), .word_in(word_in), .wordnum(wordnum), .word_id(word_id),
    .key_down(key_down), .last_change(last_change), .key_valid(key_valid),
    .ghost_num(ghost_num), .ghost_pos(ghost_pos), .busy(busy), .done(done)
  );

  always #5 clk_div = ~clk_div;

  function automatic vec_t mk(input int st, input int kv, input int lc, input int kd,
                              input int num, input int pos, input int wid,
                              input int bsy, input int dn);
    vec_t v;
    v.start = 1'(st);  v.kv = 1'(kv);   v.lc = 9'(lc);  v.kd = 9'(kd);
    v.num = 7'(num);   v.pos = 5'(pos); v.wid = 8'(wid);
    v.busy = 1'(bsy);  v.done = 1'(dn);
    return v;
  endfunction

  function automatic logic [127:0] onehot(input logic [8:0] idx);
    logic [127:0] r;
    r = '0;
    if (idx != 9'd0) r[idx[6:0]] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] sd, input logic [6:0] sp,
                               input logic [6:0] tg, input logic [74:0] w, input logic [4:0] wn);
    start = st; seed = sd; speed = sp; target = tg; word_in = w; wordnum = wn;
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk_div);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk_div);
    rst = 1'b0;
  endtask

  // Run until done (or the cycle bound) and record every key event.
  task automatic runCollect(input int maxc, output int done_cyc);
    pulse_cyc.delete(); pulse_code.delete(); pulse_make.delete();
    make_wid.delete(); make_pos.delete();
    done_cyc = -1;
    for (int n = 1; n <= maxc; n++) begin
      tick();
      if (key_valid) begin
        pulse_cyc.push_back(n);
        pulse_code.push_back(last_change);
        pulse_make.push_back(key_down != '0);
        if (key_down != '0) begin
          make_wid.push_back(word_id);
          make_pos.push_back(ghost_pos);
        end
      end
      if (done) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  int          dc;
  int          exp_cyc[6]  = '{3, 5, 6, 8, 9, 11};
  int          exp_code[6] = '{28, 28, 50, 50, 41, 41};
  logic [74:0] w15;
  logic [7:0]  m_lfsr;
  logic [8:0]  exp_mk[$];
  logic [8:0]  got_mk[$];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] ghost_typist bench starting");
    // Expected timeline for word "ab", seed 5, speed 3, target 1.
    tbl[0]  = mk(1, 0,  0,  0, 0, 0,  5, 1, 0);
    tbl[1]  = mk(1, 0,  0,  0, 0, 0,  5, 1, 0);
    tbl[2]  = mk(1, 1, 28, 28, 0, 0,  5, 1, 0);
    tbl[3]  = mk(1, 0, 28, 28, 0, 0,  5, 1, 0);
    tbl[4]  = mk(1, 1, 28,  0, 0, 0,  5, 1, 0);
    tbl[5]  = mk(1, 0, 28,  0, 0, 1,  5, 1, 0);
    tbl[6]  = mk(1, 0, 28,  0, 0, 1,  5, 1, 0);
    tbl[7]  = mk(1, 1, 50, 50, 0, 1,  5, 1, 0);
    tbl[8]  = mk(1, 0, 50, 50, 0, 1,  5, 1, 0);
    tbl[9]  = mk(1, 1, 50,  0, 0, 1,  5, 1, 0);
    tbl[10] = mk(1, 0, 50,  0, 0, 2,  5, 1, 0);
    tbl[11] = mk(1, 0, 50,  0, 0, 2,  5, 1, 0);
    tbl[12] = mk(1, 1, 41, 41, 0, 2,  5, 1, 0);
    tbl[13] = mk(1, 0, 41, 41, 0, 2,  5, 1, 0);
    tbl[14] = mk(1, 1, 41,  0, 0, 2,  5, 1, 0);
    tbl[15] = mk(1, 0, 41,  0, 1, 0, 42, 1, 0);
    tbl[16] = mk(1, 0, 41,  0, 1, 0, 42, 1, 0);
    tbl[17] = mk(0, 0, 41,  0, 1, 0, 42, 0, 1);

    // Reset values.
    doReset();
    checkOutput("rst_key_down", key_down, '0);
    checkOutput("rst_last_change", last_change, 9'd0);
    checkOutput("rst_key_valid", key_valid, 1'b0);
    checkOutput("rst_word_id", word_id, 8'd0);
    checkOutput("rst_ghost_num", ghost_num, 7'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);

    // Word "ab": full table-driven timeline; the word input is scrambled
    // after latching to show the latched copy is used.
    applyStimulus(1'b1, 8'd5, 7'd3, 7'd1, 75'h41, 5'd2);
    for (int i = 0; i < 18; i++) begin
      tick();
      checkOutput($sformatf("ab_kv_t%0d", i + 1), key_valid, tbl[i].kv);
      checkOutput($sformatf("ab_lc_t%0d", i + 1), last_change, tbl[i].lc);
      checkOutput($sformatf("ab_kd_t%0d", i + 1), key_down, onehot(tbl[i].kd));
      checkOutput($sformatf("ab_num_t%0d", i + 1), ghost_num, tbl[i].num);
      checkOutput($sformatf("ab_pos_t%0d", i + 1), ghost_pos, tbl[i].pos);
      checkOutput($sformatf("ab_wid_t%0d", i + 1), word_id, tbl[i].wid);
      checkOutput($sformatf("ab_busy_t%0d", i + 1), busy, tbl[i].busy);
      checkOutput($sformatf("ab_done_t%0d", i + 1), done, tbl[i].done);
      if (i == 2) begin
        word_in = {75{1'b1}};
        wordnum = 5'd0;
      end
      start = tbl[i].start;
    end
    tick();
    checkOutput("done_to_idle_done", done, 1'b0);
    checkOutput("done_to_idle_busy", busy, 1'b0);
    checkOutput("done_to_idle_num_kept", ghost_num, 7'd1);

    // Reset asserted mid-PRESS.
    doReset();
    applyStimulus(1'b1, 8'd5, 7'd3, 7'd1, 75'h41, 5'd2);
    tick(); tick(); tick();
    checkOutput("pre_rst_kv", key_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_key_down", key_down, '0);
    checkOutput("midrst_key_valid", key_valid, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_last_change", last_change, 9'd0);
    checkOutput("midrst_word_id", word_id, 8'd0);
    @(negedge clk_div);
    rst = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("post_rst_idle", busy, 1'b0);

    // speed 0 and speed 1 produce the same event timing.
    for (int s = 0; s < 2; s++) begin
      doReset();
      applyStimulus(1'b1, 8'd0, 7'(s), 7'd1, 75'h41, 5'd2);
      runCollect(60, dc);
      checkOutput($sformatf("sp%0d_pulses", s), pulse_cyc.size(), 6);
      if (pulse_cyc.size() == 6) begin
        for (int k = 0; k < 6; k++) begin
          checkOutput($sformatf("sp%0d_cyc%0d", s, k), pulse_cyc[k], exp_cyc[k]);
          checkOutput($sformatf("sp%0d_code%0d", s, k), pulse_code[k], exp_code[k]);
          checkOutput($sformatf("sp%0d_make%0d", s, k), pulse_make[k], (k % 2) == 0);
        end
      end
      checkOutput($sformatf("sp%0d_done_cyc", s), dc, 12);
    end

    // Two empty words with id wrap: 250 then 31.
    doReset();
    applyStimulus(1'b1, 8'd250, 7'd1, 7'd2, 75'd0, 5'd0);
    runCollect(60, dc);
    checkOutput("wrap_space_makes", make_wid.size(), 2);
    if (make_wid.size() == 2) begin
      checkOutput("wrap_wid_word1", make_wid[0], 8'd250);
      checkOutput("wrap_wid_word2", make_wid[1], 8'd31);
    end
    checkOutput("wrap_first_code", (pulse_code.size() > 0) ? pulse_code[0] : 9'd0, 9'd41);
    checkOutput("wrap_done_cyc", dc, 11);
    checkOutput("wrap_ghost_num", ghost_num, 7'd2);
    checkOutput("wrap_word_id_after", word_id, 8'd68);
    start = 1'b0;
    tick();
    checkOutput("wrap_idle_num_kept", ghost_num, 7'd2);
    checkOutput("wrap_idle_done", done, 1'b0);

    // Non-letter code in slot 0 ends the word with SPACE at once.
    doReset();
    applyStimulus(1'b1, 8'd0, 7'd1, 7'd0, 75'd91, 5'd2);
    runCollect(60, dc);
    checkOutput("badcode_pulses", pulse_cyc.size(), 2);
    checkOutput("badcode_code", (pulse_code.size() > 0) ? pulse_code[0] : 9'd0, 9'd41);
    checkOutput("badcode_done_cyc", dc, 6);
    checkOutput("badcode_num", ghost_num, 7'd1);

    // wordnum above MAX_LEN clamps to 15 letters.
    w15 = '0;
    for (int k = 0; k < 15; k++) w15[5*k +: 5] = 5'd1;
    doReset();
    applyStimulus(1'b1, 8'd0, 7'd1, 7'd1, w15, 5'd20);
    runCollect(200, dc);
    checkOutput("clamp_makes", make_pos.size(), 16);
    if (make_pos.size() == 16) begin
      checkOutput("clamp_space_pos", make_pos[15], 5'd15);
      checkOutput("clamp_pos14", make_pos[14], 5'd14);
    end
    checkOutput("clamp_done_cyc", dc, 51);

    // Abort during HOLD of 'e' (second letter of "ae").
    doReset();
    applyStimulus(1'b1, 8'd0, 7'd3, 7'd1, 75'd161, 5'd2);
    for (int n = 0; n < 9; n++) tick();
    checkOutput("abort_pre_kd", key_down, onehot(9'd36));
    start = 1'b0;
    tick();
    checkOutput("abort_kd", key_down, '0);
    checkOutput("abort_kv", key_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_pos", ghost_pos, 5'd1);
    checkOutput("abort_done", done, 1'b0);
    tick();
    checkOutput("abort_no_pulse", key_valid, 1'b0);

`ifdef GHOST_TYPO_EN
    // Typo stream against a model of the LFSR-driven mistakes.
    w15 = '0;
    for (int k = 0; k < 15; k++) w15[5*k +: 5] = 5'(k + 1);
    exp_mk.delete();
    m_lfsr = 8'hA5;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 15; k++) begin
        if (m_lfsr[2:0] == 3'd0) begin
          exp_mk.push_back(9'(scan_tbl[((k + 1) % 26) + 1]));
          exp_mk.push_back(9'd102);
        end
        exp_mk.push_back(9'(scan_tbl[k + 1]));
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
      exp_mk.push_back(9'd41);
    end
    doReset();
    applyStimulus(1'b1, 8'd0, 7'd1, 7'd4, w15, 5'd15);
    runCollect(2000, dc);
    got_mk.delete();
    for (int k = 0; k < pulse_code.size(); k++)
      if (pulse_make[k]) got_mk.push_back(pulse_code[k]);
    checkOutput("typo_make_count", got_mk.size(), exp_mk.size());
    if (got_mk.size() == exp_mk.size())
      for (int k = 0; k < exp_mk.size(); k++)
        checkOutput($sformatf("typo_make%0d", k), got_mk[k], exp_mk[k]);
    checkOutput("typo_done", dc > 0, 1'b1);
    checkOutput("typo_num", ghost_num, 7'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_typist.md
Name: ghost_typist

Overview:
- Scripted "ghost" opponent for the typing race. Generates keyboard events on the same interface the scoring logic consumes: a one-hot key_down vector, last_change and a key_valid pulse.
- Fetches words from the dictionary by id and "types" each letter as a PS/2 make/break pair, then a space, at a programmable pace.
- Runs on the 100 Hz clk_div tick. Its output feeds a second scoring instance, or a mux in front of the player scorer for demo mode.

Parameters:
- HOLD_TICKS, 2, clk_div cycles between a key's press event and its release event (min 1).
- ID_STEP, 8'd37, added mod 256 to word_id after each completed word.
- MAX_LEN, 15, maximum letters per word; slots 0..MAX_LEN-1 of word_in.

Ports:
- clk_div  in  1  100 Hz tick clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; 1 = run, 0 = abort to IDLE.
- seed  in  8  first dictionary id, sampled on IDLE->FETCH.
- speed  in  7  gap ticks from a release to the next press; 0 treated as 1.
- target  in  7  words to type before done; 0 treated as 1.
- word_in  in  75  dictionary word; letter k at [5k+4:5k], codes 1..26 = a..z.
- wordnum  in  5  letter count of word_in.
- word_id  out  8  dictionary id request.
- key_down  out  128  one-hot held-key vector.
- last_change  out  9  scan code of the most recent event.
- key_valid  out  1  1-cycle pulse per make or break event.
- ghost_num  out  7  words completed.
- ghost_pos  out  5  index of the letter currently being typed.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: key_down=0, last_change=0, key_valid=0, word_id=0, ghost_num=0, ghost_pos=0, busy=0, done=0; state=IDLE.
- Scan map (letter code -> scan code): a28 b50 c33 d35 e36 f43 g52 h51 i67 j59 k66 l75 m58 n49 o68 p77 q21 r45 s27 t44 u60 v42 w29 x34 y53 z26. SPACE=41, BACK=102.
- States: IDLE, FETCH, LATCH, PRESS, HOLD, RELEASE, GAP, DONE.
- IDLE: when start=1:
  - word_id<=seed, ghost_num<=0, ghost_pos<=0.
  - go to FETCH.
- FETCH: one cycle so the combinational dictionary settles; go to LATCH.
- LATCH: register word_in and wordnum (clamped to MAX_LEN); go to PRESS.
- Current key selection:
  - if ghost_pos < latched wordnum and the letter code is 1..26: the letter.
  - otherwise (including codes 0 or >26): SPACE.
- PRESS (1 cycle): set key_down[code]=1, last_change<=code, key_valid=1; go to HOLD.
- HOLD: count HOLD_TICKS-1 cycles, then go to RELEASE.
- RELEASE (1 cycle): clear key_down[code], key_valid=1, last_change unchanged.
  - If the key was a letter: ghost_pos+1.
  - If the key was SPACE: ghost_num+1, ghost_pos<=0, word_id<=word_id+ID_STEP (8-bit wrap).
  - Go to GAP.
- GAP: count max(speed,1) cycles, then:
  - if SPACE was just released and ghost_num==max(target,1): go to DONE.
  - else if SPACE was just released: go to FETCH.
  - else: go to PRESS.
- Timing: press-to-press period for letters = HOLD_TICKS + max(speed,1). First key_valid comes 3 cycles after start is sampled high.
- key_valid is high only in PRESS and RELEASE. At most one key_down bit is ever set.
- DONE: done=1 and all keys released; hold until start=0, then go to IDLE. ghost_num is retained until the next start.
- Abort: start=0 in any busy state goes to IDLE next cycle:
  - key_down cleared, no key_valid pulse.
  - ghost_num and ghost_pos retained.
- speed, target and seed changes mid-run take effect at the next GAP, completion check and start respectively. The latched word is immune to word_in changes.
- wordnum=0: word is just SPACE and still counts one word.
- rst asserted mid-keystroke: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro GHOST_TYPO_EN.
- Defined:
  - 8-bit LFSR (x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset) advances once per letter PRESS.
  - When LFSR[2:0]==0 on a letter, the ghost first types wrong letter (code mod 26)+1, then BACK, then the correct letter.
  - Each uses the full PRESS/HOLD/RELEASE/GAP timing.
  - ghost_pos does not advance on the typo or the BACK.
- Undefined: no LFSR; the ghost never emits BACK or wrong letters.

Test Plan:
- Reset mid-PRESS, rst pulse -> key_down=0, key_valid=0, done=0, state IDLE on the same edge.
- HOLD_TICKS=2, speed=3, seed=5, word "ab" (codes 1,2), wordnum=2, target=1, start at t0:
  - key_valid pulses at t0+3 (28 make), t0+5 (28 break), t0+8 (50), t0+10, t0+13 (41), t0+15.
  - ghost_num=1 at t0+16; done at t0+18.
- target=2, ID_STEP=37, seed=250 -> word_id 250 for word 1, then 31 (wrap) for word 2; exactly two SPACE make events.
- speed=0 -> identical timing to speed=1; wordnum=0 -> only SPACE make/break, ghost_num=1.
- start dropped while in HOLD with key_down[36] set -> next cycle key_down=0, no pulse, busy=0, ghost_pos unchanged.
- With GHOST_TYPO_EN, force a typo -> events: wrong letter, BACK (102), correct letter. Final ghost_pos equals wordnum before SPACE.
